// File: rtl/ram_access_arbiter.sv
// Clear-sweep sequencer and round-robin write/read arbiter for a single-port, read-first,
// two-stage-registered line-buffer RAM. Define RAM_ARB_FUSE_EN to merge same-address write+read.
module ram_access_arbiter #(
    parameter int                    DATA_WIDTH   = 4,
    parameter int                    RAM_DEPTH    = 5,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0,
    localparam int                   ADDRESS_BITS = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [ADDRESS_BITS-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    rd_req_valid,
    output logic                    rd_req_ready,
    input  logic [ADDRESS_BITS-1:0] rd_req_addr,
    output logic                    rd_resp_valid,
    output logic [DATA_WIDTH-1:0]   rd_resp_data,
    output logic                    init_done,
    output logic                    addr_err,
    output logic                    ram_en,
    output logic                    ram_we,
    output logic [ADDRESS_BITS-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0]   ram_di,
    input  logic [DATA_WIDTH-1:0]   ram_do
);

    localparam logic [ADDRESS_BITS-1:0] LAST_ADDR = ADDRESS_BITS'(RAM_DEPTH - 1);
    localparam logic [ADDRESS_BITS:0]   DEPTH_W   = (ADDRESS_BITS + 1)'(RAM_DEPTH);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDRESS_BITS-1:0] r_init_cnt;
    logic                    r_ptr_rd;
    logic [2:0]              r_tag_vld;
    logic [2:0]              r_tag_err;
    logic                    r_init_done;
    logic                    r_addr_err;
    logic                    r_ram_en;
    logic                    r_ram_we;
    logic [ADDRESS_BITS-1:0] r_ram_addr;
    logic [DATA_WIDTH-1:0]   r_ram_di;

    logic w_run;
    logic w_wr_ready;
    logic w_rd_ready;
    logic w_wr_oor;
    logic w_rd_oor;
    logic w_fuse;
    logic w_wr_go;
    logic w_rd_go;

    assign w_wr_oor = ({1'b0, wr_addr} >= DEPTH_W);
    assign w_rd_oor = ({1'b0, rd_req_addr} >= DEPTH_W);

`ifdef RAM_ARB_FUSE_EN
    assign w_fuse = (wr_addr == rd_req_addr) & ~w_wr_oor;
`else
    assign w_fuse = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_INIT;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_INIT && r_init_cnt == LAST_ADDR) w_state_nxt = ST_RUN;
    end

    // Readies look only at the other port's valid, so neither handshake loops on itself.
    always_comb begin
        w_run      = (r_state == ST_RUN);
        w_wr_ready = w_run & (~rd_req_valid | ~r_ptr_rd | w_fuse);
        w_rd_ready = w_run & (~wr_valid | r_ptr_rd | w_fuse);
    end

    assign w_wr_go = wr_valid & w_wr_ready;
    assign w_rd_go = rd_req_valid & w_rd_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_init_cnt <= '0;
            r_ptr_rd   <= 1'b0;
        end else begin
            if (!w_run) r_init_cnt <= r_init_cnt + 1'b1;
            if (wr_valid & rd_req_valid & w_run & ~w_fuse) r_ptr_rd <= ~r_ptr_rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_vld   <= '0;
            r_tag_err   <= '0;
            r_init_done <= 1'b0;
            r_addr_err  <= 1'b0;
            r_ram_en    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_di    <= '0;
        end else begin
            r_ram_en    <= 1'b1;
            r_init_done <= (w_state_nxt == ST_RUN);
            r_tag_vld   <= {r_tag_vld[1:0], w_rd_go};
            r_tag_err   <= {r_tag_err[1:0], w_rd_go & w_rd_oor};
            r_addr_err  <= r_addr_err | (w_wr_go & w_wr_oor) | (w_rd_go & w_rd_oor);
            if (!w_run) begin
                r_ram_we   <= 1'b1;
                r_ram_addr <= r_init_cnt;
                r_ram_di   <= INIT_VALUE;
            end else if (w_wr_go) begin
                // A fused read rides on this access; the read-first RAM returns the old word.
                r_ram_we   <= ~w_wr_oor;
                r_ram_addr <= wr_addr;
                r_ram_di   <= wr_data;
            end else if (w_rd_go) begin
                r_ram_we   <= 1'b0;
                r_ram_addr <= rd_req_addr;
            end else begin
                r_ram_we   <= 1'b0;
            end
        end
    end

    assign wr_ready      = w_wr_ready;
    assign rd_req_ready  = w_rd_ready;
    assign rd_resp_valid = r_tag_vld[2];
    assign rd_resp_data  = (r_tag_vld[2] & ~r_tag_err[2]) ? ram_do : '0;
    assign init_done     = r_init_done;
    assign addr_err      = r_addr_err;
    assign ram_en        = r_ram_en;
    assign ram_we        = r_ram_we;
    assign ram_addr      = r_ram_addr;
    assign ram_di        = r_ram_di;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench for ram_access_arbiter with a read-first, two-stage-registered RAM model.
module tb_ram_access_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [2:0] wr_addr = '0;
    logic [3:0] wr_data = '0;
    logic       rd_req_valid = 1'b0;
    logic       rd_req_ready;
    logic [2:0] rd_req_addr = '0;
    logic       rd_resp_valid;
    logic [3:0] rd_resp_data;
    logic       init_done;
    logic       addr_err;
    logic       ram_en;
    logic       ram_we;
    logic [2:0] ram_addr;
    logic [3:0] ram_di;
    logic [3:0] ram_do;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    typedef struct {int due; logic [3:0] data;} exp_t;
    exp_t q[$];

    ram_access_arbiter #(.DATA_WIDTH(4), .RAM_DEPTH(5), .INIT_VALUE(4'hA)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
        .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data),
        .init_done(init_done), .addr_err(addr_err),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_di(ram_di), .ram_do(ram_do)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Read-first RAM with two output register stages
    logic [3:0] mem [0:4];
    logic [3:0] s0, s1;
    assign ram_do = s1;
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we && ram_addr < 3'd5) mem[ram_addr] <= ram_di;
            s0 <= (ram_addr < 3'd5) ? mem[ram_addr] : 4'h0;
            s1 <= s0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0 && q[0].due == cyc) begin
            check("resp_valid", rd_resp_valid, 1);
            check("resp_data", rd_resp_data, q[0].data);
            void'(q.pop_front());
        end else begin
            check("resp_idle", rd_resp_valid, 0);
        end
    end

    task automatic next_cycle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wv, input logic [2:0] wa, input logic [3:0] wd,
                         input logic rv, input logic [2:0] ra, input logic [3:0] rexp,
                         output logic wacc, output logic racc);
        wr_valid = wv; wr_addr = wa; wr_data = wd;
        rd_req_valid = rv; rd_req_addr = ra;
        #1;
        wacc = wv & wr_ready;
        racc = rv & rd_req_ready;
        if (racc) q.push_back('{cyc + 3, rexp});
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        rd_req_valid = 1'b0;
    endtask

    task automatic init_sequence();
        wr_valid = 1'b1;
        rd_req_valid = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("init_wr_rdy", wr_ready, 0);
            check("init_rd_rdy", rd_req_ready, 0);
            check("init_done_lo", init_done, 0);
            if (i > 0) begin
                check("init_addr", ram_addr, i - 1);
                check("init_we", ram_we, 1);
                check("init_di", ram_di, 4'hA);
            end
            next_cycle(1);
        end
        wr_valid = 1'b0;
        rd_req_valid = 1'b0;
        #1;
        check("init_done_hi", init_done, 1);
        check("init_last_addr", ram_addr, 4);
        check("init_last_we", ram_we, 1);
        check("run_en", ram_en, 1);
        check("run_wr_rdy", wr_ready, 1);
        check("run_rd_rdy", rd_req_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic wa, ra;
        next_cycle(2);
        check("rst_init_done", init_done, 0);
        check("rst_addr_err", addr_err, 0);
        check("rst_resp_valid", rd_resp_valid, 0);
        check("rst_ram_en", ram_en, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_di", ram_di, 0);
        check("rst_wr_rdy", wr_ready, 0);
        rst_n = 1'b1;
        init_sequence();

        // Back-to-back reads of the cleared words
        for (int i = 0; i < 5; i++) begin
            issue(1'b0, 3'd0, 4'h0, 1'b1, 3'(i), 4'hA, wa, ra);
            check("init_rd_acc", ra, 1);
            check("init_rd_we", ram_we, 0);
            check("init_rd_addr", ram_addr, i);
        end
        next_cycle(4);

        // Write then read-after-write
        issue(1'b1, 3'd2, 4'h5, 1'b0, 3'd0, 4'h0, wa, ra);
        check("wr_acc", wa, 1);
        check("wr_pin_we", ram_we, 1);
        check("wr_pin_addr", ram_addr, 2);
        check("wr_pin_di", ram_di, 4'h5);
        issue(1'b0, 3'd0, 4'h0, 1'b1, 3'd2, 4'h5, wa, ra);
        check("raw_acc", ra, 1);
        next_cycle(4);

        // Contention: grants alternate W,R,W,R starting with write
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, 3'd1, 4'h3, 1'b1, 3'd0, 4'hA, wa, ra);
            check("arb_wr_grant", wa, (i % 2 == 0) ? 1 : 0);
            check("arb_rd_grant", ra, (i % 2 == 1) ? 1 : 0);
            check("arb_pin_we", ram_we, (i % 2 == 0) ? 1 : 0);
            check("arb_pin_addr", ram_addr, (i % 2 == 0) ? 1 : 0);
        end
        next_cycle(1);
        check("idle_we", ram_we, 0);
        check("idle_addr_hold", ram_addr, 0);
        next_cycle(3);

        // Out-of-range accesses
        check("err_pre", addr_err, 0);
        issue(1'b0, 3'd0, 4'h0, 1'b1, 3'd7, 4'h0, wa, ra);
        check("oor_rd_acc", ra, 1);
        check("err_set", addr_err, 1);
        issue(1'b1, 3'd6, 4'hF, 1'b0, 3'd0, 4'h0, wa, ra);
        check("oor_wr_acc", wa, 1);
        check("oor_wr_we", ram_we, 0);
        next_cycle(4);
        check("err_sticky", addr_err, 1);

        // Same-address write and read in one cycle
        issue(1'b1, 3'd3, 4'h1, 1'b0, 3'd0, 4'h0, wa, ra);
        next_cycle(1);
`ifdef RAM_ARB_FUSE_EN
        issue(1'b1, 3'd3, 4'h9, 1'b1, 3'd3, 4'h1, wa, ra);
        check("fuse_wr_acc", wa, 1);
        check("fuse_rd_acc", ra, 1);
        check("fuse_we", ram_we, 1);
`else
        issue(1'b1, 3'd3, 4'h9, 1'b1, 3'd3, 4'h1, wa, ra);
        check("nofuse_wr_acc", wa, 1);
        check("nofuse_rd_acc", ra, 0);
        issue(1'b0, 3'd0, 4'h0, 1'b1, 3'd3, 4'h9, wa, ra);
        check("nofuse_rd_late", ra, 1);
`endif
        next_cycle(1);
        issue(1'b0, 3'd0, 4'h0, 1'b1, 3'd3, 4'h9, wa, ra);
        check("fuse_after_acc", ra, 1);
        next_cycle(4);

        // Reset with two reads in flight
        issue(1'b0, 3'd0, 4'h0, 1'b1, 3'd0, 4'hA, wa, ra);
        issue(1'b0, 3'd0, 4'h0, 1'b1, 3'd1, 4'h3, wa, ra);
        rst_n = 1'b0;
        q.delete();
        next_cycle(2);
        check("rst2_init_done", init_done, 0);
        check("rst2_addr_err", addr_err, 0);
        rst_n = 1'b1;
        init_sequence();
        issue(1'b0, 3'd0, 4'h0, 1'b1, 3'd2, 4'hA, wa, ra);
        check("post_rst_acc", ra, 1);
        next_cycle(5);
        check("queue_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
